// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller slice: bus widths, burst
// length, the write-trigger FSM encoding and the controller NOP command.
package sdram_pkg;

   localparam int SDRAM_DW    = 16;
   localparam int SDRAM_BURST = 8;

   // One-hot encoding keeps each state decode down to a single flop bit.
   typedef enum logic [2:0] {
      T_IDLE = 3'b001,
      T_FIRE = 3'b010,
      T_WAIT = 3'b100
   } trig_state_t;

   // {cs_n, ras_n, cas_n, we_n} for the SDRAM NOP command.
   localparam logic [3:0] CMD_NOP = 4'b0111;

endpackage

// File: rtl/sdram_wbuf_ram.sv
// Simple dual-port storage for the SDRAM write buffer: one write port and
// one read port whose output register only loads when rd_en is high, so the
// last read word is held between pops.
module sdram_wbuf_ram #(
   parameter int DW = 16,
   parameter int AW = 9
) (
   input  logic          sclk,
   input  logic          s_rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(2**AW)-1];

   // Write port: storage array has no reset so it maps onto block RAM.
   always_ff @(posedge sclk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Read port: registered output that holds its value until the next read.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sdram_wr_buf.sv
// User-side write buffer feeding the SDRAM write path. Accepts words over a
// valid/ready handshake into a circular buffer, serves them through the
// wfifo_* pop interface and pulses wr_trig once per rising crossing of the
// burst threshold.
// Optional feature: define SDRAM_WR_BUF_UNDERFLOW_EN to enable the sticky
// pop-while-empty flag err_underflow; otherwise the port is tied to 0.
import sdram_pkg::*;

module sdram_wr_buf #(
   parameter int DW    = SDRAM_DW,
   parameter int AW    = 9,
   parameter int BURST = SDRAM_BURST
) (
   input  logic          sclk,
   input  logic          s_rst_n,
   input  logic          flush,
   input  logic          din_valid,
   input  logic [DW-1:0] din_data,
   output logic          din_ready,
   input  logic          wfifo_rd_en,
   output logic [DW-1:0] wfifo_rd_data,
   output logic          wfifo_deepth_eight,
   output logic          wr_trig,
   output logic [AW:0]   level,
   output logic          err_underflow
);

   localparam logic [AW:0] ONE       = 1;
   localparam logic [AW:0] BURST_LVL = BURST[AW:0];

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   trig_state_t trig_state;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // No bypass: a full buffer refuses a word even while it is being popped,
   // and a pop on an empty buffer never sees the same-cycle push.
   assign din_ready = !full;
   assign push      = din_valid && !full && !flush;
   assign pop       = wfifo_rd_en && !empty && !flush;

   assign wfifo_deepth_eight = (level >= BURST_LVL);

   sdram_wbuf_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .wr_en   (push),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (din_data),
      .rd_en   (pop),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (wfifo_rd_data)
   );

   // Pointer and level bookkeeping; flush wins over any push or pop.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ONE;
         if (pop)
            rd_ptr <= rd_ptr + ONE;
         if (push && !pop)
            level <= level + ONE;
         else if (pop && !push)
            level <= level - ONE;
      end
   end

   // Trigger FSM: fire once when the level reaches a burst, then wait for
   // the level to fall back below the threshold before re-arming.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         trig_state <= T_IDLE;
         wr_trig    <= 1'b0;
      end else if (flush) begin
         trig_state <= T_IDLE;
         wr_trig    <= 1'b0;
      end else begin
         case (trig_state)
            T_IDLE: begin
               if (level >= BURST_LVL) begin
                  trig_state <= T_FIRE;
                  wr_trig    <= 1'b1;
               end else begin
                  wr_trig    <= 1'b0;
               end
            end
            T_FIRE: begin
               trig_state <= T_WAIT;
               wr_trig    <= 1'b0;
            end
            T_WAIT: begin
               wr_trig <= 1'b0;
               if (level < BURST_LVL)
                  trig_state <= T_IDLE;
            end
            default: begin
               trig_state <= T_IDLE;
               wr_trig    <= 1'b0;
            end
         endcase
      end
   end

`ifdef SDRAM_WR_BUF_UNDERFLOW_EN
   // Sticky flag for pop requests that arrive while the buffer is empty.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)
         err_underflow <= 1'b0;
      else if (flush)
         err_underflow <= 1'b0;
      else if (wfifo_rd_en && empty)
         err_underflow <= 1'b1;
   end
`else
   assign err_underflow = 1'b0;
`endif

endmodule
